// File: rtl/cpu_mc_if.sv
// Shared instruction/data memory port of cpu_mc: req/ack handshake, one word per transfer.
// The core drives the request through the master modport; memory/arbiter answers on the slave side.
interface cpu_mc_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit-encoding RISC core with one shared wait-state-tolerant memory port.
// Optional macro CPU_MC_R0_ZERO_EN: register 0 is hardwired to zero (writes discarded).
module cpu_mc #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       NREGS    = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic     clk,
   input  logic     rst_n,
   cpu_mc_if.master mem,
   output logic     halted
);
   localparam int unsigned RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND   = 4'h2, OP_OR   = 4'h3,
      OP_XOR  = 4'h4, OP_SLT  = 4'h5, OP_ADDI  = 4'h6, OP_LDI  = 4'h7,
      OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BEQ   = 4'hA, OP_BNE  = 4'hB,
      OP_JUMP = 4'hC, OP_HALT = 4'hD, OP_NOP_E = 4'hE, OP_NOP_F = 4'hF
   } op_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       inst_q;
   logic [DATA_W-1:0] rf_q [NREGS];
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              halted_q;

   op_e               op;
   logic [RI_W-1:0]   rd_idx, rs_idx, rt_idx;
   logic [DATA_W-1:0] rd_v, rs_v, rt_v, ea, alu_d, rf_wd;
   logic [ADDR_W-1:0] pc_inc, br_tgt, pc_d, ea_addr;
   logic              alu_we, rf_we, r0_wr_ok;

`ifdef CPU_MC_R0_ZERO_EN
   assign r0_wr_ok = (rd_idx != '0);
`else
   assign r0_wr_ok = 1'b1;
`endif

   always_comb begin
      op      = op_e'(inst_q[15:12]);
      rd_idx  = inst_q[8 +: RI_W];
      rs_idx  = inst_q[4 +: RI_W];
      rt_idx  = inst_q[0 +: RI_W];
      rd_v    = rf_q[rd_idx];
      rs_v    = rf_q[rs_idx];
      rt_v    = rf_q[rt_idx];
      ea      = rs_v + {{(DATA_W-4){inst_q[3]}}, inst_q[3:0]};
      ea_addr = ADDR_W'(ea);
      pc_inc  = pc_q + ADDR_W'(1);
      br_tgt  = pc_q + {{(ADDR_W-4){inst_q[3]}}, inst_q[3:0]};
      alu_d   = '0;
      alu_we  = 1'b0;
      pc_d    = pc_inc;
      case (op)
         OP_ADD:  begin alu_d = rs_v + rt_v;  alu_we = 1'b1; end
         OP_SUB:  begin alu_d = rs_v - rt_v;  alu_we = 1'b1; end
         OP_AND:  begin alu_d = rs_v & rt_v;  alu_we = 1'b1; end
         OP_OR:   begin alu_d = rs_v | rt_v;  alu_we = 1'b1; end
         OP_XOR:  begin alu_d = rs_v ^ rt_v;  alu_we = 1'b1; end
         OP_SLT:  begin alu_d = (rs_v < rt_v) ? DATA_W'(1) : '0; alu_we = 1'b1; end
         OP_ADDI: begin alu_d = rd_v + {{(DATA_W-8){inst_q[7]}}, inst_q[7:0]}; alu_we = 1'b1; end
         OP_LDI:  begin alu_d = DATA_W'(inst_q[7:0]); alu_we = 1'b1; end
         OP_BEQ:  pc_d = (rd_v == rs_v) ? br_tgt : pc_inc;
         OP_BNE:  pc_d = (rd_v != rs_v) ? br_tgt : pc_inc;
         OP_JUMP: pc_d = ADDR_W'(inst_q[7:0]);
         default: ;
      endcase

      // Single register write port shared by ALU results (EXEC) and load data (MEM).
      rf_we = (state_q == S_EXEC) && alu_we;
      rf_wd = alu_d;
      if (state_q == S_MEM && req_q && mem.mem_ack && !we_q) begin
         rf_we = 1'b1;
         rf_wd = mem.mem_rdata;
      end
      rf_we = rf_we && r0_wr_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         inst_q   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         halted_q <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         if (rf_we) rf_q[rd_idx] <= rf_wd;
         case (state_q)
            // Only the first fetch after reset needs this idle cycle; later fetches
            // are requested directly from EXEC/MEM so ALU ops take 2 cycles.
            S_FETCH: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= pc_q;
               end else if (mem.mem_ack) begin
                  inst_q  <= mem.mem_rdata[15:0];
                  req_q   <= 1'b0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_LD, OP_ST: begin
                     req_q   <= 1'b1;
                     we_q    <= (op == OP_ST);
                     addr_q  <= ea_addr;
                     wdata_q <= rd_v;
                     state_q <= S_MEM;
                  end
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALT;
                  end
                  default: begin
                     pc_q    <= pc_d;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= pc_d;
                     state_q <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (mem.mem_ack) begin
                  pc_q    <= pc_inc;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= pc_inc;
                  state_q <= S_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign halted        = halted_q;
endmodule
